cannon_sequencer: RTL
=====================

// Module: cannon_sequencer
// PURPOSE
//  Command sequencer sitting directly upstream of the message_passer PE array. Drives one full
//  Cannon-style matrix multiply: RESET, LOAD (A/B pre-skewed by the loader), then N rounds of
//  MULTIPLY, each followed (except the last) by SHIFT_LEFT of A and SHIFT_UP of B.
//  Broadcasts one command at a time and runs the ready/ack handshake against the AND of all PE ready outputs.
// PARAMETERS
//  N               4     array dimension = number of multiply rounds (N >= 1)
//  CNT_W           8     width of round counter; must hold N-1
//  TIMEOUT_CYCLES  1024  watchdog limit per command (used only with CANNON_SEQ_TIMEOUT_EN)
// PORTS
//  CLK             in   1      single clock, rising edge
//  reset_n         in   1      asynchronous, active-low reset
//  start           in   1      begin a sequence; sampled only in IDLE
//  ready_all       in   1      AND-reduction of every PE ready output
//  cmd             out  3      command_to_execute to the array: 000 mul, 001 up, 011 left, 101 load, 111 reset
//  cmd_valid       out  1      cmd is live; the array wrapper gates PE execution with it
//  image_to_shift  out  1      0 = A, 1 = B; meaningful only with shift commands
//  ack             out  1      one-cycle pulse that clears PE ready
//  busy            out  1      high from leaving IDLE until DONE/ERR
//  done            out  1      one-cycle pulse on sequence completion
//  error           out  1      sticky watchdog error (CANNON_SEQ_TIMEOUT_EN only; otherwise tied 0)
//  round           out  CNT_W  current multiply round, 0..N-1
// BEHAVIOUR
//  - All outputs are registered. On reset_n low, all outputs are 0 immediately and the state is IDLE.
//  - Reset asserted mid-sequence aborts the sequence; no done pulse is produced.
//  - States: IDLE, CMD, ACK, CLR, DONE, ERR.
//  - IDLE: start=1 -> load cmd=111 (first step), busy=1, round=0, go to CMD.
//  - CMD: cmd_valid=1 with cmd/image_to_shift stable.
//    - ready_all=1 -> ACK.
//  - ACK: cmd_valid=0, ack=1 for exactly one cycle -> CLR.
//  - CLR: ack=0; wait for ready_all=0. If ready_all remains high, stay in CLR (never re-ack).
//    Once ready_all=0: load the next step and go to CMD, or go to DONE after the final step.
//  - Step order: 111, 101, then for r = 0..N-1: 000 [, 011 with img=0, 001 with img=1 if r < N-1].
//    - round increments when the 001 step completes.
//  - Total commands = 3N. Each command takes a minimum of 3 cycles (CMD, ACK, CLR).
//  - N=1: 111, 101, 000, then DONE; no shifts are issued.
//  - DONE: done=1 and busy=0 for one cycle -> IDLE. start is ignored while busy; it is not queued.
//  - start and DONE in the same cycle: start is ignored; a new start is accepted from the next IDLE cycle.
//  - cmd holds the last issued value while idle; cmd_valid=0 is the only indication that no command is live.
// CONFIGURATION
//  CANNON_SEQ_TIMEOUT_EN defined:
//    - A per-command counter clears on entry to CMD and counts while in CMD or CLR.
//    - When the counter reaches TIMEOUT_CYCLES: go to ERR, with error=1, busy=0, cmd_valid=0.
//    - ERR is left only via reset_n.
//  CANNON_SEQ_TIMEOUT_EN undefined:
//    - No counter logic; error is constant 0.
//    - The FSM waits indefinitely in CMD or CLR.
// TESTING
//  1. N=4, ready_all model answers 1 cycle after cmd_valid and drops 1 cycle after ack ->
//     cmd trace is 111,101,000,011,001,000,011,001,000,011,001,000 with images 0/1 on the shifts;
//     exactly 12 ack pulses; done pulses once; round ends at 3.
//  2. N=1 -> trace 111,101,000; no 011/001 issued; done after 3 acks.
//  3. start pulsed again during round 1 -> ignored; trace is identical to scenario 1; exactly one done.
//  4. reset_n low during the 2nd MULTIPLY -> all outputs are 0 the same cycle;
//     a following start runs a full 12-command trace.
//  5. ready_all held 1 for 5 cycles after ack -> FSM stays in CLR with no second ack;
//     it advances one cycle after ready_all falls.
//  6. With CANNON_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, ready_all stuck 0 in the first CMD ->
//     error=1 after 16 cycles; start is then ignored until reset.
//     Without the macro: still in CMD after 100 cycles, error=0.

Source files
------------

// File: rtl/cannon_sequencer.sv
// Cannon matrix-multiply command sequencer: issues RESET, LOAD, then N rounds of MULTIPLY/SHIFT to the PE array.
// Optional per-command watchdog enabled by defining CANNON_SEQ_TIMEOUT_EN.
module cannon_sequencer #(
    parameter int N              = 4,
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             start,
    input  logic             ready_all,
    output logic [2:0]       cmd,
    output logic             cmd_valid,
    output logic             image_to_shift,
    output logic             ack,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] round,
    output logic [2:0]       state_dbg
);

    // Handshake: a command is live while cmd_valid=1; the array answers with ready_all=1,
    // the sequencer pulses ack for one cycle, then waits for ready_all=0 before the next command.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_ACK  = 3'd2,
        S_CLR  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        P_RST  = 3'd0,
        P_LOAD = 3'd1,
        P_MUL  = 3'd2,
        P_LEFT = 3'd3,
        P_UP   = 3'd4
    } phase_t;

    localparam logic [2:0]       CMD_MUL    = 3'b000;
    localparam logic [2:0]       CMD_UP     = 3'b001;
    localparam logic [2:0]       CMD_LEFT   = 3'b011;
    localparam logic [2:0]       CMD_LOAD   = 3'b101;
    localparam logic [2:0]       CMD_RESET  = 3'b111;
    localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(N - 1);

    state_t           state, state_d;
    phase_t           phase, phase_d;
    logic [CNT_W-1:0] round_d;
    logic [2:0]       cmd_d;
    logic             img_d;
    logic             timed_out;

    function automatic logic [2:0] cmd_of(input phase_t p);
        case (p)
            P_RST:   cmd_of = CMD_RESET;
            P_LOAD:  cmd_of = CMD_LOAD;
            P_MUL:   cmd_of = CMD_MUL;
            P_LEFT:  cmd_of = CMD_LEFT;
            P_UP:    cmd_of = CMD_UP;
            default: cmd_of = CMD_MUL;
        endcase
    endfunction

    always_comb begin
        state_d = state;
        phase_d = phase;
        round_d = round;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CMD;
                    phase_d = P_RST;
                    round_d = '0;
                end
            end
            S_CMD: begin
                if (ready_all) begin
                    state_d = S_ACK;
                end else if (timed_out) begin
                    state_d = S_ERR;
                end
            end
            S_ACK: state_d = S_CLR;
            S_CLR: begin
                if (!ready_all) begin
                    state_d = S_CMD;
                    case (phase)
                        P_RST:  phase_d = P_LOAD;
                        P_LOAD: phase_d = P_MUL;
                        P_MUL: begin
                            if (round == LAST_ROUND) begin
                                state_d = S_DONE;
                            end else begin
                                phase_d = P_LEFT;
                            end
                        end
                        P_LEFT: phase_d = P_UP;
                        P_UP: begin
                            phase_d = P_MUL;
                            round_d = round + CNT_W'(1);
                        end
                        default: state_d = S_DONE;
                    endcase
                end else if (timed_out) begin
                    state_d = S_ERR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    // cmd and image only change when a new command goes live, so they hold while idle.
    always_comb begin
        cmd_d = cmd;
        img_d = image_to_shift;
        if (state_d == S_CMD) begin
            cmd_d = cmd_of(phase_d);
            img_d = (phase_d == P_UP);
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            phase          <= P_RST;
            round          <= '0;
            cmd            <= '0;
            image_to_shift <= 1'b0;
            cmd_valid      <= 1'b0;
            ack            <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state          <= state_d;
            phase          <= phase_d;
            round          <= round_d;
            cmd            <= cmd_d;
            image_to_shift <= img_d;
            cmd_valid      <= (state_d == S_CMD);
            ack            <= (state_d == S_ACK);
            busy           <= (state_d == S_CMD) || (state_d == S_ACK) || (state_d == S_CLR);
            done           <= (state_d == S_DONE);
        end
    end

    assign state_dbg = state;

`ifdef CANNON_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Counter restarts for each new command and keeps running across the ACK/CLR wait.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
        end else if ((state_d == S_CMD) && (state != S_CMD)) begin
            tmo_cnt <= '0;
        end else if ((state == S_CMD) || (state == S_CLR)) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    assign timed_out = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            error <= 1'b0;
        end else begin
            error <= (state_d == S_ERR);
        end
    end
`else
    assign timed_out = 1'b0;
    assign error     = 1'b0;
`endif

endmodule
